// File: rtl/reg_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : reg_scoreboard_ctrl
// Purpose : Issue controller for the RV64 decode/register-file stage.
//           Tracks registers with long-latency writebacks pending (loads,
//           mul/div) in a 32-entry scoreboard. Blocks issue on RAW/WAW
//           hazards and when the outstanding-op limit is reached. Also
//           sequences the pipeline flush after a redirect, and the pipeline
//           drain for fence/ecall.
// Ports   : clk, rst               clock / async active-high reset
//           i_id_*                 decoded instruction held in ID
//           o_issue_ready          comb; issue fires on i_id_valid & ready
//           i_wb_valid, i_wb_rd    long-latency writeback (clears)
//           i_redirect             1-cycle pulse, taken branch/jump
//           i_drain_req            level, held until o_drain_done
//           o_flush_id_ex          registered squash of IF/ID and ID/EX
//           o_drain_done           registered 1-cycle pulse, pipeline empty
//           o_busy_vec             scoreboard bits (bit 0 always 0)
//           o_out_cnt              outstanding long-latency op count
//           o_sb_err               sticky: writeback for non-pending reg
// Revision: 1.0 - initial release
// ============================================================================
module reg_scoreboard_ctrl #(
  parameter int MAX_OUT      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_id_valid,
  input  logic [4:0]                   i_id_rs1,
  input  logic [4:0]                   i_id_rs2,
  input  logic [4:0]                   i_id_rd,
  input  logic                         i_id_use_rs1,
  input  logic                         i_id_use_rs2,
  input  logic                         i_id_long,
  output logic                         o_issue_ready,
  input  logic                         i_wb_valid,
  input  logic [4:0]                   i_wb_rd,
  input  logic                         i_redirect,
  input  logic                         i_drain_req,
  output logic                         o_flush_id_ex,
  output logic                         o_drain_done,
  output logic [31:0]                  o_busy_vec,
  output logic [$clog2(MAX_OUT+1)-1:0] o_out_cnt,
  output logic                         o_sb_err
);

  localparam int c_cnt_w  = $clog2(MAX_OUT + 1);
  localparam int c_fcnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_max_out   = c_cnt_w'(MAX_OUT);
  localparam logic [c_fcnt_w-1:0] c_fcnt_load = c_fcnt_w'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_fcnt_w-1:0]   r_fcnt;
  logic                  r_flush;
  logic                  r_drain_done;
  logic [31:0]           r_busy;
  logic [c_cnt_w-1:0]    r_out_cnt;
  logic                  r_sb_err;

  logic [31:0]           w_wb_onehot;
  logic [31:0]           w_rd_onehot;
  logic [31:0]           w_clr_vec;
  logic [31:0]           w_busy_eff;
  logic [31:0]           w_set_vec;
  logic [31:0]           w_busy_next;
  logic                  w_clr_any;
  logic                  w_raw;
  logic                  w_waw;
  logic [c_cnt_w-1:0]    w_cnt_net;
  logic                  w_full;
  logic                  w_issue_ready;
  logic                  w_fire;
  logic                  w_inc;
  logic                  w_x0_wb;
  logic                  w_dec;
  logic                  w_wb_err;
  logic [c_cnt_w-1:0]    w_cnt_next;

  assign w_wb_onehot = 32'd1 << i_wb_rd;
  assign w_rd_onehot = 32'd1 << i_id_rd;

  // A writeback in this cycle already counts as cleared for hazard checks,
  // so a dependent instruction can issue in the same cycle as its producer
  // writes back.
  assign w_clr_vec  = i_wb_valid ? (w_wb_onehot & r_busy) : 32'd0;
  assign w_busy_eff = r_busy & ~w_clr_vec;
  assign w_clr_any  = |w_clr_vec;

  assign w_raw = (i_id_use_rs1 & (i_id_rs1 != 5'd0) & w_busy_eff[i_id_rs1]) |
                 (i_id_use_rs2 & (i_id_rs2 != 5'd0) & w_busy_eff[i_id_rs2]);
  assign w_waw = i_id_long & (i_id_rd != 5'd0) & w_busy_eff[i_id_rd];

  assign w_cnt_net = r_out_cnt - c_cnt_w'(w_clr_any);
  assign w_full    = i_id_long & (w_cnt_net >= c_max_out);

  assign w_issue_ready = (r_state == ST_RUN) & ~i_redirect & ~w_raw & ~w_waw & ~w_full;
  assign w_fire        = i_id_valid & w_issue_ready;
  assign w_inc         = w_fire & i_id_long;

  // A long op targeting x0 sets no bit but is still outstanding.
  assign w_set_vec = (w_inc & (i_id_rd != 5'd0)) ? w_rd_onehot : 32'd0;

  // Set is OR'ed after clear so a same-cycle re-issue to the same rd keeps
  // the bit pending. Bit 0 is forced low.
  assign w_busy_next = (w_busy_eff | w_set_vec) & 32'hFFFF_FFFE;

  // x0 writebacks retire an x0 long op; they are legal only while
  // something is outstanding.
  assign w_x0_wb  = i_wb_valid & (i_wb_rd == 5'd0) & (r_out_cnt != '0);
  assign w_dec    = w_clr_any | w_x0_wb;
  assign w_wb_err = i_wb_valid & ~w_dec;

  always_comb begin
    w_cnt_next = r_out_cnt;
    if (w_inc && !w_dec) begin
      if (r_out_cnt != c_max_out) w_cnt_next = r_out_cnt + c_cnt_w'(1);
    end else if (!w_inc && w_dec) begin
      if (r_out_cnt != '0) w_cnt_next = r_out_cnt - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_fcnt       <= '0;
      r_flush      <= 1'b0;
      r_drain_done <= 1'b0;
      r_busy       <= 32'd0;
      r_out_cnt    <= '0;
      r_sb_err     <= 1'b0;
    end else begin
      r_busy       <= w_busy_next;
      r_out_cnt    <= w_cnt_next;
      r_drain_done <= 1'b0;
      if (w_wb_err) r_sb_err <= 1'b1;

      case (r_state)
        ST_RUN: begin
          if (i_redirect) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= c_fcnt_load;
            r_flush <= 1'b1;
          end else if (i_drain_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_FLUSH: begin
          if (i_redirect) begin
            r_fcnt  <= c_fcnt_load;
            r_flush <= 1'b1;
          end else if (r_fcnt == '0) begin
            r_state <= ST_RUN;
            r_flush <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - c_fcnt_w'(1);
          end
        end
        ST_DRAIN: begin
          // A redirect interrupts the drain; it resumes via RUN afterwards
          // because the requester still holds i_drain_req.
          if (i_redirect) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= c_fcnt_load;
            r_flush <= 1'b1;
          end else if (w_cnt_next == '0) begin
            r_state      <= ST_RUN;
            r_drain_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign o_issue_ready = w_issue_ready;
  assign o_flush_id_ex = r_flush;
  assign o_drain_done  = r_drain_done;
  assign o_busy_vec    = r_busy;
  assign o_out_cnt     = r_out_cnt;
  assign o_sb_err      = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_scoreboard_ctrl
// Purpose : Directed self-checking bench for reg_scoreboard_ctrl
//           (MAX_OUT=4, FLUSH_CYCLES=2). Expected scoreboard state is queued
//           when stimulus is driven and compared after the clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_long;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        redirect, drain_req;
  logic        flush_id_ex, drain_done, sb_err;
  logic [31:0] busy_vec;
  logic [2:0]  out_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] busy;
    logic [2:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_scoreboard_ctrl #(.MAX_OUT(4), .FLUSH_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rd       (id_rd),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_id_long     (id_long),
    .o_issue_ready (issue_ready),
    .i_wb_valid    (wb_valid),
    .i_wb_rd       (wb_rd),
    .i_redirect    (redirect),
    .i_drain_req   (drain_req),
    .o_flush_id_ex (flush_id_ex),
    .o_drain_done  (drain_done),
    .o_busy_vec    (busy_vec),
    .o_out_cnt     (out_cnt),
    .o_sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] b, input logic [2:0] c);
    exp_t e;
    e.tag  = tag;
    e.busy = b;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then compare every queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, "_busy"}, busy_vec, e.busy);
      check({e.tag, "_cnt"}, {29'd0, out_cnt}, {29'd0, e.cnt});
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2, input logic lg);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_long = lg;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
  endtask

  initial begin
    logic [31:0] eb;
    logic [4:0]  wl [4];
    int          fc;

    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    redirect  = 1'b0;
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_vec, 32'd0);
    check("rst_cnt", {29'd0, out_cnt}, 32'd0);
    check("rst_flush", {31'd0, flush_id_ex}, 32'd0);
    check("rst_drain_done", {31'd0, drain_done}, 32'd0);
    check("rst_sb_err", {31'd0, sb_err}, 32'd0);
    rst = 1'b0;
    tick();

    // ---- 1: load-use hazard with same-cycle writeback bypass ----
    set_id(1, 0, 0, 5, 0, 0, 1);
    #1 check("t1_ld_ready", {31'd0, issue_ready}, 32'd1);
    push_exp("t1_ld", 32'h0000_0020, 3'd1);
    tick();
    set_id(1, 5, 1, 6, 1, 1, 0);
    #1 check("t1_raw_stall0", {31'd0, issue_ready}, 32'd0);
    push_exp("t1_stall", 32'h0000_0020, 3'd1);
    tick();
    check("t1_raw_stall1", {31'd0, issue_ready}, 32'd0);
    set_wb(1, 5);
    #1 check("t1_bypass_ready", {31'd0, issue_ready}, 32'd1);
    push_exp("t1_wb", 32'd0, 3'd0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);

    // ---- 2: outstanding limit ----
    eb = 32'd0;
    for (int i = 1; i <= 4; i++) begin
      set_id(1, 0, 0, 5'(i), 0, 0, 1);
      eb = eb | (32'd1 << i);
      #1 check($sformatf("t2_ready_x%0d", i), {31'd0, issue_ready}, 32'd1);
      push_exp($sformatf("t2_issue_x%0d", i), eb, 3'(i));
      tick();
    end
    set_id(1, 0, 0, 7, 0, 0, 1);
    #1 check("t2_full_stall", {31'd0, issue_ready}, 32'd0);
    set_id(1, 8, 9, 10, 1, 1, 0);
    #1 check("t2_nonlong_ready", {31'd0, issue_ready}, 32'd1);
    push_exp("t2_nonlong", 32'h0000_001E, 3'd4);
    tick();
    set_id(1, 0, 0, 7, 0, 0, 1);
    set_wb(1, 1);
    #1 check("t2_wb_unblock", {31'd0, issue_ready}, 32'd1);
    push_exp("t2_fifth", 32'h0000_009C, 3'd4);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    wl[0] = 5'd2; wl[1] = 5'd3; wl[2] = 5'd4; wl[3] = 5'd7;
    eb = 32'h0000_009C;
    for (int i = 0; i < 4; i++) begin
      set_wb(1, wl[i]);
      eb = eb & ~(32'd1 << wl[i]);
      push_exp($sformatf("t2_wb_x%0d", wl[i]), eb, 3'(3 - i));
      tick();
    end
    set_wb(0, 0);

    // ---- 3: redirect / flush ----
    set_id(1, 8, 9, 10, 1, 1, 0);
    redirect = 1'b1;
    #1 check("t3_redirect_blocks", {31'd0, issue_ready}, 32'd0);
    tick();
    redirect = 1'b0;
    fc = 0;
    for (int k = 0; k < 8; k++) begin
      if (flush_id_ex) fc++;
      tick();
    end
    check("t3_single_flush_len", fc, 32'd2);
    check("t3_ready_after", {31'd0, issue_ready}, 32'd1);
    set_id(0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b1;
    tick();
    fc = 0;
    for (int k = 0; k < 8; k++) begin
      if (flush_id_ex) fc++;
      redirect = (k == 0);
      tick();
    end
    redirect = 1'b0;
    check("t3_double_flush_len", fc, 32'd3);

    // ---- 4: drain ----
    set_id(1, 0, 0, 11, 0, 0, 1);
    push_exp("t4_ld11", 32'h0000_0800, 3'd1);
    tick();
    set_id(1, 0, 0, 12, 0, 0, 1);
    push_exp("t4_ld12", 32'h0000_1800, 3'd2);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    drain_req = 1'b1;
    tick();
    set_id(1, 8, 9, 10, 1, 1, 0);
    #1 check("t4_drain_block", {31'd0, issue_ready}, 32'd0);
    set_wb(1, 11);
    push_exp("t4_wb11", 32'h0000_1000, 3'd1);
    tick();
    check("t4_not_done_yet", {31'd0, drain_done}, 32'd0);
    set_wb(1, 12);
    push_exp("t4_wb12", 32'd0, 3'd0);
    tick();
    check("t4_drain_done", {31'd0, drain_done}, 32'd1);
    drain_req = 1'b0;
    set_wb(0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("t4_done_pulse_end", {31'd0, drain_done}, 32'd0);
    set_id(1, 8, 9, 10, 1, 1, 0);
    #1 check("t4_run_ready", {31'd0, issue_ready}, 32'd1);
    set_id(0, 0, 0, 0, 0, 0, 0);

    // ---- 5: same-cycle WB and re-issue to the same rd ----
    set_id(1, 0, 0, 13, 0, 0, 1);
    push_exp("t5_ld13", 32'h0000_2000, 3'd1);
    tick();
    set_wb(1, 13);
    #1 check("t5_reissue_ready", {31'd0, issue_ready}, 32'd1);
    push_exp("t5_set_wins", 32'h0000_2000, 3'd1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    push_exp("t5_clean", 32'd0, 3'd0);
    tick();
    set_wb(0, 0);

    // ---- 6: error, x0 long ops, async reset ----
    set_wb(1, 9);
    push_exp("t6_bad_wb", 32'd0, 3'd0);
    tick();
    check("t6_sb_err", {31'd0, sb_err}, 32'd1);
    set_wb(0, 0);
    tick();
    check("t6_sb_err_sticky", {31'd0, sb_err}, 32'd1);
    set_id(1, 0, 0, 0, 0, 0, 1);
    push_exp("t6_ld_x0", 32'd0, 3'd1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("t6_async_rst_cnt", {29'd0, out_cnt}, 32'd0);
    check("t6_async_rst_err", {31'd0, sb_err}, 32'd0);
    rst = 1'b0;
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1);
    push_exp("t6_ld_x0_b", 32'd0, 3'd1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 0);
    push_exp("t6_wb_x0", 32'd0, 3'd0);
    tick();
    check("t6_x0_wb_no_err", {31'd0, sb_err}, 32'd0);
    push_exp("t6_wb_x0_empty", 32'd0, 3'd0);
    tick();
    check("t6_x0_wb_empty_err", {31'd0, sb_err}, 32'd1);
    set_wb(0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
